// File: rtl/multitrack_master_fsm.sv
// multitrack_master_fsm
//   Top-level control FSM for the keyboard recorder. It supports recording
//   over several tracks and playing the whole song back with either looping
//   or stop-at-end. It can also clear the selected track. It owns the song
//   position counter. It edge-detects the keyboard level state, so a held key
//   acts exactly once.
//
// Ports
//   clk               single clock
//   resetn            asynchronous reset, active HIGH (name kept from the
//                     surrounding design)
//   inputStateStorage level state of every key, synchronous to clk
//   tick              one-cycle time-base strobe
//   loopMode          1: playback wraps at song end, 0: playback stops
//   currentState      state code, also used for screen selection
//   timerEnable       downstream timer run enable (registered)
//   timerClear        one-cycle pulse whenever position is returned to 0
//   recordEnable      qualifies note writes into track activeTrack
//   activeTrack       currently selected track
//   trackValid        bit i set when track i holds a recording
//   position          current song position in ticks
//   songLength        length of the longest recorded track in ticks

module multitrack_master_fsm #(
  parameter int NUM_KEYS       = 30,
  parameter int NUM_TRACKS     = 4,
  parameter int TRACK_W        = 2,
  parameter int TIME_W         = 16,
  parameter int KEY_REC        = 15,
  parameter int KEY_SPACE      = 28,
  parameter int KEY_RESTART    = 18,
  parameter int KEY_CLEAR      = 13,
  parameter int KEY_TRACK_BASE = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_KEYS-1:0]   inputStateStorage,
  input  logic                  tick,
  input  logic                  loopMode,
  output logic [4:0]            currentState,
  output logic                  timerEnable,
  output logic                  timerClear,
  output logic                  recordEnable,
  output logic [TRACK_W-1:0]    activeTrack,
  output logic [NUM_TRACKS-1:0] trackValid,
  output logic [TIME_W-1:0]     position,
  output logic [TIME_W-1:0]     songLength
);

  typedef enum logic [4:0] {
    STARTSCREEN     = 5'd0,
    RECORD          = 5'd1,
    PLAYBACK        = 5'd2,
    RESTARTPLAYBACK = 5'd3,
    PLAYEND         = 5'd4,
    RESTARTRECORD   = 5'd5
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [NUM_KEYS-1:0]   prevKeys;
  logic [NUM_KEYS-1:0]   keyEvent;
  logic                  evRec;
  logic                  evSpace;
  logic                  evRestart;
  logic                  evClear;
  logic                  trackHit;
  logic [TRACK_W-1:0]    trackSel;
  logic [TRACK_W-1:0]    trackNext;
  logic [NUM_TRACKS-1:0] validNext;
  logic [TIME_W-1:0]     positionNext;
  logic [TIME_W-1:0]     lengthNext;
  logic                  atMax;
  logic                  songEnd;
  logic                  wrapNow;
  logic                  unusedKeyEvents;

  // Key rising edges. prevKeys resets to all ones so keys held through
  // reset do not fire when reset is released.
  assign keyEvent  = inputStateStorage & ~prevKeys;
  assign evRec     = keyEvent[KEY_REC];
  assign evSpace   = keyEvent[KEY_SPACE];
  assign evRestart = keyEvent[KEY_RESTART];
  assign evClear   = keyEvent[KEY_CLEAR];

  // Keys that no command decodes are folded here so that they count as consumed.
  assign unusedKeyEvents = ^keyEvent;

  assign atMax   = &position;
  assign songEnd = (songLength == '0) ||
                   (tick && (position == songLength - TIME_W'(1)));

  assign currentState = state;

  // Track-key decode. If several track keys fire together, the lowest index wins.
  always_comb begin
    trackHit = 1'b0;
    trackSel = '0;
    for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
      if (!trackHit && keyEvent[KEY_TRACK_BASE + i]) begin
        trackHit = 1'b1;
        trackSel = TRACK_W'(i);
      end
    end
  end

  always_comb begin
    stateNext    = state;
    trackNext    = activeTrack;
    validNext    = trackValid;
    lengthNext   = songLength;
    positionNext = position;
    wrapNow      = 1'b0;

    case (state)
      STARTSCREEN: begin
        if (evRec) begin
          stateNext = RESTARTRECORD;
        end else if (evClear) begin
          validNext[activeTrack] = 1'b0;
          // songLength is not recomputed from the remaining tracks. It drops
          // to 0 only when no recorded track remains.
          if (validNext == '0) begin
            lengthNext = '0;
          end
        end
        if (trackHit) begin
          trackNext = trackSel;
        end
      end

      RESTARTRECORD: begin
        stateNext    = RECORD;
        positionNext = '0;
      end

      RECORD: begin
        if (tick && !atMax) begin
          positionNext = position + TIME_W'(1);
        end
        // The last tick at full scale stops the take. position holds at its maximum.
        if (evSpace || (tick && atMax)) begin
          stateNext              = RESTARTPLAYBACK;
          validNext[activeTrack] = 1'b1;
          if (position > songLength) begin
            lengthNext = position;
          end
        end
      end

      PLAYBACK: begin
        if (tick) begin
          positionNext = position + TIME_W'(1);
        end
        if (trackHit) begin
          trackNext = trackSel;
        end
        if (evRestart) begin
          stateNext = RESTARTPLAYBACK;
        end else if (evSpace) begin
          stateNext = RESTARTRECORD;
        end else if (songEnd) begin
          if (loopMode && (songLength != '0)) begin
            positionNext = '0;
            wrapNow      = 1'b1;
          end else begin
            stateNext    = PLAYEND;
            positionNext = position;
          end
        end
      end

      RESTARTPLAYBACK: begin
        stateNext    = PLAYBACK;
        positionNext = '0;
      end

      PLAYEND: begin
        if (trackHit) begin
          trackNext = trackSel;
        end
        if (evRestart) begin
          stateNext = RESTARTPLAYBACK;
        end else if (evSpace) begin
          stateNext = RESTARTRECORD;
        end else if (evRec) begin
          stateNext = STARTSCREEN;
        end
      end

      default: stateNext = STARTSCREEN;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= STARTSCREEN;
      prevKeys     <= '1;
      activeTrack  <= '0;
      trackValid   <= '0;
      position     <= '0;
      songLength   <= '0;
      timerEnable  <= 1'b0;
      timerClear   <= 1'b0;
      recordEnable <= 1'b0;
    end else begin
      state        <= stateNext;
      prevKeys     <= inputStateStorage;
      activeTrack  <= trackNext;
      trackValid   <= validNext;
      position     <= positionNext;
      songLength   <= lengthNext;
      // The outputs are registered from the present state, so they lag currentState by one cycle.
      timerEnable  <= (state == RECORD) || (state == PLAYBACK);
      recordEnable <= (state == RECORD);
      timerClear   <= (state == RESTARTRECORD) || (state == RESTARTPLAYBACK) ||
                      wrapNow;
    end
  end

endmodule

// File: tb/tb_multitrack_master_fsm.sv
module tb_multitrack_master_fsm;

  localparam int NK    = 30;
  localparam int NT    = 4;
  localparam int TW    = 4;
  localparam int MAXP  = 15;
  localparam int K_REC = 15;
  localparam int K_SP  = 28;
  localparam int K_R   = 18;
  localparam int K_BS  = 13;
  localparam int K_TB  = 1;

  localparam int S_START = 0, S_REC = 1, S_PLAY = 2, S_RPLAY = 3, S_END = 4, S_RREC = 5;

  logic           clk;
  logic           resetn;
  logic [NK-1:0]  kin;
  logic           tick;
  logic           loopMode;
  logic [4:0]     currentState;
  logic           timerEnable;
  logic           timerClear;
  logic           recordEnable;
  logic [1:0]     activeTrack;
  logic [NT-1:0]  trackValid;
  logic [TW-1:0]  position;
  logic [TW-1:0]  songLength;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          mState, mTrack, mPos, mLen;
  bit [NT-1:0] mValid;
  bit [NK-1:0] mPrev;
  bit          eTE, eRE, eTC;

  int keyList[10] = '{15, 28, 18, 13, 1, 2, 3, 4, 0, 20};

  multitrack_master_fsm #(
    .NUM_KEYS(NK),
    .NUM_TRACKS(NT),
    .TRACK_W(2),
    .TIME_W(TW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .inputStateStorage(kin),
    .tick(tick),
    .loopMode(loopMode),
    .currentState(currentState),
    .timerEnable(timerEnable),
    .timerClear(timerClear),
    .recordEnable(recordEnable),
    .activeTrack(activeTrack),
    .trackValid(trackValid),
    .position(position),
    .songLength(songLength)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mState = S_START; mTrack = 0; mPos = 0; mLen = 0;
    mValid = '0; mPrev = '1;
    eTE = 0; eRE = 0; eTC = 0;
  endtask

  // One clock edge of the recorder, from the behavioural rules.
  task automatic modelStep();
    bit [NK-1:0] ev;
    int sel, ns;
    bit wrap;
    if (resetn) begin
      modelReset();
      return;
    end
    ev = kin & ~mPrev;
    mPrev = kin;
    sel = -1;
    for (int i = NT - 1; i >= 0; i--) if (ev[K_TB + i]) sel = i;
    wrap = 0;
    ns = mState;
    eTE = (mState == S_REC) || (mState == S_PLAY);
    eRE = (mState == S_REC);
    case (mState)
      S_START: begin
        if (ev[K_REC]) ns = S_RREC;
        else if (ev[K_BS]) begin
          mValid[mTrack] = 1'b0;
          if (mValid == 0) mLen = 0;
        end
        if (sel >= 0) mTrack = sel;
      end
      S_RREC: begin ns = S_REC; mPos = 0; end
      S_REC: begin
        if (ev[K_SP] || (tick && mPos == MAXP)) begin
          ns = S_RPLAY;
          mValid[mTrack] = 1'b1;
          if (mPos > mLen) mLen = mPos;
        end
        if (tick && mPos != MAXP) mPos = mPos + 1;
      end
      S_PLAY: begin
        if (sel >= 0) mTrack = sel;
        if (ev[K_R] || ev[K_SP]) begin
          ns = ev[K_R] ? S_RPLAY : S_RREC;
          if (tick) mPos = (mPos + 1) % (MAXP + 1);
        end else if (mLen == 0 || (tick && mPos + 1 == mLen)) begin
          if (loopMode && mLen != 0) begin mPos = 0; wrap = 1; end
          else ns = S_END;
        end else if (tick) mPos = mPos + 1;
      end
      S_RPLAY: begin ns = S_PLAY; mPos = 0; end
      S_END: begin
        if (sel >= 0) mTrack = sel;
        if (ev[K_R]) ns = S_RPLAY;
        else if (ev[K_SP]) ns = S_RREC;
        else if (ev[K_REC]) ns = S_START;
      end
      default: ns = S_START;
    endcase
    eTC = (mState == S_RREC) || (mState == S_RPLAY) || wrap;
    mState = ns;
  endtask

  task automatic checkAll();
    chk("state", currentState, mState);
    chk("track", activeTrack, mTrack);
    chk("valid", trackValid, mValid);
    chk("pos", position, mPos);
    chk("len", songLength, mLen);
    chk("timerEnable", timerEnable, eTE);
    chk("timerClear", timerClear, eTC);
    chk("recordEnable", recordEnable, eRE);
  endtask

  task automatic cyc(input logic [NK-1:0] k, input logic t);
    kin = k;
    tick = t;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  function automatic logic [NK-1:0] key(input int idx);
    logic [NK-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic tap(input int idx);
    cyc(key(idx), 1'b0);
    cyc('0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc('0, 1'b1);
      cyc('0, 1'b0);
    end
  endtask

  initial begin
    resetn = 1'b1;
    kin = key(K_REC);
    tick = 1'b0;
    loopMode = 1'b1;
    modelReset();

    // reset, with Q held through the release
    cyc(key(K_REC), 1'b0);
    chk("rstState", currentState, 0);
    chk("rstPos", position, 0);
    chk("rstTimerClear", timerClear, 0);
    chk("rstValid", trackValid, 0);
    cyc(key(K_REC), 1'b0);
    resetn = 1'b0;
    repeat (3) cyc(key(K_REC), 1'b0);
    chk("heldQ", currentState, S_START);
    cyc('0, 1'b0);
    cyc(key(K_REC), 1'b0);
    chk("qRestartRec", currentState, 5);
    cyc('0, 1'b0);
    chk("qRecord", currentState, 1);
    chk("qTcPulse", timerClear, 1);
    cyc('0, 1'b0);
    chk("qTcDone", timerClear, 0);
    chk("qRecEn", recordEnable, 1);

    // asynchronous reset mid-record discards the take
    ticks(3);
    #2;
    resetn = 1'b1;
    modelReset();
    #1;
    checkAll();
    chk("midRstValid", trackValid, 0);
    chk("midRstState", currentState, 0);
    cyc('0, 1'b0);
    resetn = 1'b0;
    cyc('0, 1'b0);

    // record track 0 for 10 ticks, then loop
    tap(K_REC);
    ticks(10);
    chk("rec10Pos", position, 10);
    cyc(key(K_SP), 1'b0);
    chk("rec10Valid", trackValid, 4'b0001);
    chk("rec10Len", songLength, 10);
    cyc('0, 1'b0);
    chk("playEntryPos", position, 0);
    ticks(9);
    chk("preWrapPos", position, 9);
    cyc('0, 1'b1);
    chk("wrapPos", position, 0);
    chk("wrapTc", timerClear, 1);
    chk("wrapState", currentState, S_PLAY);
    cyc('0, 1'b0);

    // overdub on track 2
    tap(3);
    chk("selTrack2", activeTrack, 2);
    tap(K_SP);
    ticks(4);
    cyc(key(K_SP), 1'b0);
    chk("dubValid", trackValid, 4'b0101);
    chk("dubLen", songLength, 10);
    cyc('0, 1'b0);
    tap(K_SP);
    ticks(15);
    cyc(key(K_SP), 1'b0);
    chk("dubLen15", songLength, 15);
    cyc('0, 1'b0);

    // stop at end
    loopMode = 1'b0;
    ticks(15);
    chk("stopState", currentState, S_END);
    chk("stopTimerEn", timerEnable, 0);
    cyc(key(K_R), 1'b0);
    chk("restartState", currentState, S_RPLAY);
    cyc('0, 1'b0);
    chk("restartPlay", currentState, S_PLAY);
    chk("restartPos", position, 0);

    // simultaneous R+SPACE, simultaneous track keys
    cyc(key(K_R) | key(K_SP), 1'b0);
    chk("rWins", currentState, S_RPLAY);
    cyc('0, 1'b0);
    cyc(key(1) | key(3), 1'b0);
    chk("lowTrackWins", activeTrack, 0);
    cyc('0, 1'b0);

    // clear both tracks, then an empty song
    ticks(15);
    tap(K_REC);
    chk("backToStart", currentState, S_START);
    tap(K_BS);
    chk("clr0Valid", trackValid, 4'b0100);
    chk("clr0Len", songLength, 15);
    tap(3);
    tap(K_BS);
    chk("clrAllValid", trackValid, 0);
    chk("clrAllLen", songLength, 0);
    tap(K_REC);
    cyc(key(K_SP), 1'b0);
    cyc('0, 1'b0);
    chk("emptyPlay", currentState, S_PLAY);
    cyc('0, 1'b0);
    chk("emptyEnd", currentState, S_END);

    // saturation stops the take
    tap(K_SP);
    ticks(15);
    chk("satPos", position, 15);
    cyc('0, 1'b1);
    chk("satState", currentState, S_RPLAY);
    chk("satLen", songLength, 15);
    cyc('0, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [NK-1:0] k;
      int r;
      k = '0;
      r = $urandom_range(0, 11);
      if (r < 2) k = key(keyList[$urandom_range(0, 9)]);
      else if (r == 2) k = key(keyList[$urandom_range(0, 9)]) | key(keyList[$urandom_range(0, 9)]);
      if (c % 400 == 0) loopMode = 1'($urandom_range(0, 1));
      if (c == 1700) begin
        #2;
        resetn = 1'b1;
        modelReset();
        #1;
        checkAll();
        cyc('0, 1'b0);
        resetn = 1'b0;
      end
      cyc(k, 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multitrack_master_fsm.md
# multitrack_master_fsm

Parametrised top-level control FSM for the keyboard recorder. It adds multi-track recording, playback of the full song with loop or stop-at-end, and per-track clearing. It also owns the song position counter and adds key edge detection, so a held key fires exactly once. It sits between the keyboard input-state storage and the note RAM / audio playback datapath; its state code drives screen selection.

## Interface
- NUM_KEYS, 30: width of inputStateStorage.
- NUM_TRACKS, 4: number of recordable tracks, 1..9.
- TRACK_W, 2: width of activeTrack; must satisfy 2^TRACK_W >= NUM_TRACKS.
- TIME_W, 16: width of position and songLength, in ticks.
- KEY_REC, 15 (Q): start recording.
- KEY_SPACE, 28: toggle record/playback.
- KEY_RESTART, 18 (R): restart playback.
- KEY_CLEAR, 13 (Backspace): clear the active track.
- KEY_TRACK_BASE, 1: key index that selects track 0; track i uses key KEY_TRACK_BASE+i.

Ports:
- clk, input, 1: single clock.
- resetn, input, 1: **asynchronous, active-high** reset (the name is kept for consistency with the rest of the design).
- inputStateStorage, input, NUM_KEYS: level state of each key, synchronous to clk.
- tick, input, 1: time-base strobe, one clk cycle wide.
- loopMode, input, 1: 1 means playback wraps at song end; 0 means playback stops at song end.
- currentState, output, 5: state code.
- timerEnable, output, 1: downstream timer run enable.
- timerClear, output, 1: one-cycle pulse whenever position is reset to 0.
- recordEnable, output, 1: qualifies note writes into track activeTrack.
- activeTrack, output, TRACK_W: selected track.
- trackValid, output, NUM_TRACKS: bit i set means track i holds a recording.
- position, output, TIME_W: current song position in ticks.
- songLength, output, TIME_W: length of the longest valid track.

## Operation
- **Edge detection.** A key event is `inputStateStorage & ~prevKeys`. prevKeys is registered every cycle and resets to all ones, so keys held through reset never fire. Only events drive transitions; levels are ignored.
- **State codes:** STARTSCREEN=0, RECORD=1, PLAYBACK=2, RESTARTPLAYBACK=3, PLAYEND=4, RESTARTRECORD=5. Any other code goes to STARTSCREEN on the next cycle.
- **Transitions.** Where several events occur in the same cycle, the first listed wins.
  - STARTSCREEN: REC goes to RESTARTRECORD. CLEAR clears trackValid[activeTrack] and stays.
  - RESTARTRECORD: always goes to RECORD; position=0.
  - RECORD: SPACE goes to RESTARTPLAYBACK. Position saturation also goes to RESTARTPLAYBACK (tick while position is all ones).
  - Leaving RECORD: set trackValid[activeTrack]; songLength = max(songLength, position).
  - PLAYBACK: RESTART goes to RESTARTPLAYBACK; SPACE goes to RESTARTRECORD; otherwise end-of-song handling applies.
  - End of song in PLAYBACK is a tick while position == songLength-1, or songLength == 0.
    - loopMode=1 and songLength != 0: position goes to 0, timerClear pulses, state stays PLAYBACK.
    - Otherwise: go to PLAYEND.
  - RESTARTPLAYBACK: always goes to PLAYBACK; position=0.
  - PLAYEND: RESTART goes to RESTARTPLAYBACK; SPACE goes to RESTARTRECORD; REC goes to STARTSCREEN.
- **Track select.** A track-key event in STARTSCREEN, PLAYBACK or PLAYEND loads activeTrack. If several track keys fire together, the lowest index wins. Track keys are ignored in all other states.
- **Clearing.** songLength resets to 0 when a clear leaves trackValid all zero. Otherwise songLength is unchanged; it is not recomputed.
- **Position.** position increments on tick only in RECORD and PLAYBACK.
- **Moore outputs:**
  - timerEnable = state is RECORD or PLAYBACK.
  - recordEnable = state is RECORD.
  - timerClear = state is RESTARTRECORD or RESTARTPLAYBACK, or the loop wrap cycle.

## Timing
- Reset values: currentState=0, activeTrack=0, trackValid=0, position=0, songLength=0, timerEnable=0, timerClear=0, recordEnable=0.
- A key rising level first seen at clock edge k changes currentState at edge k. Moore outputs follow one cycle later.
- The restart states last exactly 1 cycle. Any key event during them is discarded.
- tick in a restart cycle is ignored, so position is 0 on entry to RECORD or PLAYBACK.
- The trackValid and songLength updates take effect at the same edge that leaves RECORD.
- Asserting reset mid-record discards the recording: trackValid stays 0.

## Test plan
- **Reset with keys held:** hold Q through reset release → stays STARTSCREEN. Release Q, then press it → codes 5 then 1; timerClear high for 1 cycle.
- **Record then loop:** record track 0 for 10 ticks, then SPACE → trackValid=0001, songLength=10. With loopMode=1, after 10 ticks position wraps 9→0 and timerClear pulses.
- **Overdub:** select track 2 (key 3) and record 4 ticks → trackValid=0101, songLength stays 10. Record 15 ticks instead → songLength=15.
- **Stop at end:** with loopMode=0, the end of song goes to PLAYEND with timerEnable=0. R → 3 then 2, position=0.
- **Simultaneous R+SPACE in PLAYBACK:** R wins, giving RESTARTPLAYBACK. Press keys 1 and 3 together → activeTrack=0.
- **Clear and saturation:**
  - Clear both valid tracks → trackValid=0, songLength=0. PLAYBACK then enters PLAYEND in 1 cycle.
  - With TIME_W=4, record 16 ticks → auto-stop; songLength=15.
